// File: rtl/fpnew_noncomp_outbuf.sv
// fpnew_noncomp_outbuf: boxing result FIFO behind the non-computational FP slice.
// Define FPNEW_NONCOMP_FFLAGS_ACC_EN to add sticky exception flag accumulation.
module fpnew_noncomp_outbuf #(
  parameter int unsigned Width    = 32,
  parameter int unsigned RegWidth = 64,
  parameter int unsigned Depth    = 2,
  parameter type         TagType  = logic,
  parameter type         AuxType  = logic
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Width-1:0]    result_i,
  input  logic [4:0]          status_i,
  input  logic                extension_bit_i,
  input  TagType              tag_i,
  input  AuxType              aux_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [RegWidth-1:0] result_o,
  output logic [4:0]          status_o,
  output TagType              tag_o,
  output AuxType              aux_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
`ifdef FPNEW_NONCOMP_FFLAGS_ACC_EN
  ,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i
`endif
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  typedef struct packed {
    logic [RegWidth-1:0] result;
    logic [4:0]          status;
    TagType              tag;
    AuxType              aux;
  } entry_t;
  entry_t              mem_q [Depth];
  entry_t              wr_entry, head;
  logic [RegWidth-1:0] boxed;
  logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                push, pop;
  if (RegWidth > Width) begin : g_box
    assign boxed = {{(RegWidth-Width){extension_bit_i}}, result_i};
  end else begin : g_nobox
    assign boxed = result_i;
  end
  // Ready comes from the registered count only, so out_ready_i never reaches the slice.
  always_comb begin
    in_ready_o  = cnt_q < CntW'(Depth);
    out_valid_o = cnt_q != '0;
    busy_o      = cnt_q != '0;
    push        = in_valid_i && in_ready_o && !flush_i;
    pop         = out_valid_o && out_ready_i && !flush_i;
    wr_entry    = '{result: boxed, status: status_i, tag: tag_i, aux: aux_i};
    head        = out_valid_o ? mem_q[rptr_q] : '0;
    wptr_d      = flush_i ? '0 : push ? (wptr_q == PtrW'(Depth-1) ? '0 : wptr_q + PtrW'(1)) : wptr_q;
    rptr_d      = flush_i ? '0 : pop ? (rptr_q == PtrW'(Depth-1) ? '0 : rptr_q + PtrW'(1)) : rptr_q;
    cnt_d       = flush_i ? '0 : cnt_q + CntW'(push) - CntW'(pop);
  end
  assign result_o = head.result;
  assign status_o = head.status;
  assign tag_o    = head.tag;
  assign aux_o    = head.aux;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_entry;
  end
`ifdef FPNEW_NONCOMP_FFLAGS_ACC_EN
  logic [4:0] fflags_q, fflags_d;
  // A clear coinciding with a pop keeps the popped status rather than dropping it.
  always_comb begin
    fflags_d = fflags_clr_i ? (pop ? head.status : 5'b0) : (pop ? fflags_q | head.status : fflags_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fflags_q <= '0;
    else fflags_q <= fflags_d;
  end
  assign fflags_o = fflags_q;
`endif
endmodule

// File: doc/fpnew_noncomp_outbuf.md
# fpnew_noncomp_outbuf

Result buffer placed directly downstream of the non-computational FP slice (sign-injection / min-max / compare). It accepts one result per valid/ready handshake, NaN-boxes or sign-extends it to register width using the slice's extension bit, stores it in a small FIFO, and presents it to the writeback arbiter. It breaks the combinational `out_ready` path back into the slice and optionally accumulates sticky exception flags.

## Interface
- `Width`, 32: width of slice result (FP format width).
- `RegWidth`, 64: destination register width; must be >= `Width`.
- `Depth`, 2: FIFO entries, 1..8.
- `TagType`, logic: opaque tag carried with each result.
- `AuxType`, logic: opaque aux data carried with each result.

Ports:
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `result_i`  in  Width  slice result.
- `status_i`  in  5  status {NV,DZ,OF,UF,NX}.
- `extension_bit_i`  in  1  fill bit for upper register bits.
- `tag_i` / `aux_i`  in  TagType / AuxType  sideband.
- `in_valid_i`  in  1  upstream valid.
- `in_ready_o`  out  1  buffer can accept.
- `flush_i`  in  1  discard all buffered entries.
- `result_o`  out  RegWidth  boxed head result.
- `status_o`  out  5  head status.
- `tag_o` / `aux_o`  out  TagType / AuxType  head sideband.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  downstream ready.
- `busy_o`  out  1  any entry held.
- `fflags_o`  out  5  sticky accumulated flags (macro only).
- `fflags_clr_i`  in  1  clear sticky flags (macro only).

## Operation
- Storage: `Depth` entries of {boxed result, status, tag, aux}; read/write pointers wrap modulo `Depth`; occupancy counter `$clog2(Depth+1)` bits.
- Boxing at write: stored result = {(RegWidth-Width) copies of `extension_bit_i`, `result_i`}; when RegWidth == Width, no fill.
- Push = `in_valid_i && in_ready_o && !flush_i`. Pop = `out_valid_o && out_ready_i && !flush_i`.
- `in_ready_o` = (count < Depth), derived from registered count only; no combinational dependence on `out_ready_i`. When full, no push in the same cycle as a pop.
- `out_valid_o` = (count != 0). `busy_o` = (count != 0).
- Push and pop together: count unchanged, both pointers advance.
- `result_o`, `status_o`, `tag_o`, `aux_o` driven from the head entry when `out_valid_o`, else all zero.
- Head data is stable while `out_valid_o && !out_ready_i` (AXI-style hold).
- Flush: count and both pointers cleared at next edge; input in the flush cycle is dropped; `out_valid_o` low the cycle after.

## Timing
- Latency: accepted in cycle N -> `out_valid_o` high in N+1 (min one cycle; no bypass).
- Throughput: one result/cycle when Depth >= 2 and downstream always ready; Depth = 1 gives one result every 2 cycles.
- Reset (async assert): count=0, pointers=0, `out_valid_o`=0, `busy_o`=0, `in_ready_o`=1, `result_o`/`status_o`/`tag_o`/`aux_o`=0, `fflags_o`=0. Reset mid-transfer discards all entries.
- Storage arrays need no reset; outputs zeroed by the empty mux.

## Configuration
- `FPNEW_NONCOMP_FFLAGS_ACC_EN` defined: `fflags_o`/`fflags_clr_i` exist. On pop, fflags <= fflags | popped status. `fflags_clr_i` synchronous: clr alone -> 0; clr with pop -> popped status. Flush does not affect fflags.
- Undefined: ports and register absent; no sticky state.

## Test plan
- Width=32, RegWidth=64, Depth=2: push 0x7FC00000 ext=1 -> next cycle `out_valid_o`=1, `result_o`=0xFFFFFFFF_7FC00000; push 0x00000001 ext=0 -> 0x00000000_00000001.
- Hold `out_ready_i`=0, push 2 results -> `in_ready_o`=0 after second, third `in_valid_i` not accepted; release -> results emerge in order, tags 1,2.
- Continuous valid, `out_ready_i`=1 -> one output per cycle, 8 results in 9 cycles, order preserved.
- Two entries buffered, assert `flush_i` with concurrent `in_valid_i` -> next cycle count=0, `out_valid_o`=0, `busy_o`=0, flushed input never appears.
- Macro on: pop statuses 0x10 then 0x01 -> `fflags_o`=0x11; `fflags_clr_i` with pop of 0x04 -> `fflags_o`=0x04.
- Drop `rst_ni` while 1 entry held -> outputs zero immediately, `in_ready_o`=1.
